load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter NUMWORDS, default 4096, meaning the number of 32-bit words in the downstream memory.
REQ-002 The block SHALL have localparam ADDR_SIZE = $clog2(NUMWORDS), meaning the word-address width.
REQ-003 The clock SHALL be clk_i  input  1  clock; reset SHALL be rst_i  input  1  asynchronous, active-high.
REQ-004 The CPU request port SHALL be:
- req_valid_i  input  1  request present
- req_ready_o  output  1  unit idle, request accepted when valid&ready
- req_we_i  input  1  1=store, 0=load
- req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  input  1  zero-extend load
- req_addr_i  input  32  byte address
- req_wdata_i  input  32  store data, right-aligned
REQ-005 The CPU response port SHALL be:
- resp_valid_o  output  1  one-cycle response pulse
- resp_rdata_o  output  32  load result, 0 for stores
- resp_err_o  output  1  misaligned/illegal/out-of-range
REQ-006 The memory port SHALL be:
- mem_read_en_o  output  1
- mem_read_addr_o  output  ADDR_SIZE
- mem_read_valid_i  input  1
- mem_read_data_i  input  32
- mem_write_en_o  output  1
- mem_write_addr_o  output  ADDR_SIZE
- mem_write_data_o  output  32

Function
REQ-007 The FSM SHALL have states IDLE, READ, WRITE, RESP; all outputs SHALL be registered.
REQ-008 req_ready_o SHALL be 1 only in IDLE; a request accepted at cycle T SHALL be captured (addr, size, unsigned, we, wdata) at T.
REQ-009 An accepted request SHALL be an error if: size==11; half with addr[0]=1; word with addr[1:0]!=0; or addr[31:2] >= NUMWORDS.
REQ-010 An error SHALL transition IDLE->RESP with no memory access; the response SHALL have resp_err_o=1 and resp_rdata_o=0.
REQ-011 Transitions from IDLE SHALL be: load or sub-word store -> READ; word store -> WRITE.
REQ-012 In READ, mem_read_en_o SHALL be 1 and mem_read_addr_o SHALL be held equal to addr[ADDR_SIZE+1:2] until the cycle mem_read_valid_i=1, which exits READ.
REQ-013 Exit from READ SHALL go to RESP for a load and to WRITE for a sub-word store.
REQ-014 mem_read_valid_i SHALL be ignored outside READ.
REQ-015 Load extraction SHALL be little-endian:
- byte: lane addr[1:0]
- half: lane addr[1]
- word: unchanged
- result sign-extended unless the captured unsigned flag is set.
REQ-016 A sub-word store SHALL merge read data with wdata[7:0] into byte lane addr[1:0] (byte) or wdata[15:0] into half lane addr[1] (half); other bytes SHALL be unchanged.
REQ-017 WRITE SHALL last exactly one cycle with mem_write_en_o=1, word address, and merged/full data, then go to RESP.
REQ-018 RESP SHALL last exactly one cycle with resp_valid_o=1, then go to IDLE; there SHALL be no response backpressure.
REQ-019 Latency with memory delay D (cycles from read_en to read_valid) SHALL be: word store, resp at T+3; load, resp at T+D+3; sub-word store, resp at T+D+4; error, resp at T+2.
REQ-020 mem_read_en_o and mem_write_en_o SHALL never be 1 in the same cycle.

Reset
REQ-021 While rst_i=1 the block SHALL be in IDLE, with req_ready_o=1 and every other output 0, including the data and address outputs.
REQ-022 Reset asserted mid-operation SHALL abandon the operation with no memory write issued and no response issued; mem_read_valid_i arriving after reset SHALL be ignored.

Verification
REQ-023 Memory word 5 = 0x8899AABB; load byte, addr 0x16, signed -> resp_rdata_o=0xFFFFFF99, resp_err_o=0.
REQ-024 Same word; load half, addr 0x14, unsigned -> resp_rdata_o=0x0000AABB.
REQ-025 Same word; store byte 0x11 at addr 0x15 -> one read, then write to word 5 with data 0x889911BB; resp at T+D+4.
REQ-026 Load word at addr 0x3 -> resp_err_o=1 at T+2, no mem_read_en_o/mem_write_en_o pulse; load at addr 0x4000 with NUMWORDS=4096 -> resp_err_o=1.
REQ-027 Word store 0xDEADBEEF at addr 0x8 -> mem_write_en_o=1 at T+2 with mem_write_addr_o=2, resp_valid_o at T+3.
REQ-028 rst_i pulsed while in READ during a sub-word store -> no write issued, no response, req_ready_o=1 after release, and a stray mem_read_valid_i is ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit with read-modify-write for sub-word stores
module load_store_unit #(
    parameter int NUMWORDS = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [1:0]           req_size_i,
    input  logic                 req_unsigned_i,
    input  logic [31:0]          req_addr_i,
    input  logic [31:0]          req_wdata_i,
    output logic                 resp_valid_o,
    output logic [31:0]          resp_rdata_o,
    output logic                 resp_err_o,
    output logic                 mem_read_en_o,
    output logic [$clog2(NUMWORDS)-1:0] mem_read_addr_o,
    input  logic                 mem_read_valid_i,
    input  logic [31:0]          mem_read_data_i,
    output logic                 mem_write_en_o,
    output logic [$clog2(NUMWORDS)-1:0] mem_write_addr_o,
    output logic [31:0]          mem_write_data_o
);
    localparam int ADDR_SIZE = $clog2(NUMWORDS);
    localparam logic [31:0] NUMWORDS_W = 32'(NUMWORDS);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                state_q, state_d;
    logic                  pend_q, pend_d;
    logic [31:0]           addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic                  we_q, we_d;
    logic [31:0]           wdata_q, wdata_d;

    logic                  ready_q, ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_SIZE-1:0]  rd_addr_q, rd_addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;

    logic [ADDR_SIZE-1:0]  word_addr;
    logic                  req_err;
    logic [4:0]            shamt;
    logic [31:0]           lane;
    logic [31:0]           lane_mask;
    logic [31:0]           merged;
    logic [31:0]           load_val;

    assign word_addr = addr_q[ADDR_SIZE+1:2];
    assign req_err   = (size_q == 2'b11)
                    || (size_q == 2'b01 && addr_q[0])
                    || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
                    || ({2'b00, addr_q[31:2]} >= NUMWORDS_W);

    // Half accesses are always half-aligned here, so one byte-granular shift serves both sizes.
    assign shamt     = {addr_q[1:0], 3'b000};
    assign lane      = mem_read_data_i >> shamt;
    assign lane_mask = (size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff;
    assign merged    = (mem_read_data_i & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);

    always_comb begin
        load_val = mem_read_data_i;
        case (size_q)
            2'b00:   load_val = uns_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_val = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_val = mem_read_data_i;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        addr_d       = addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        rd_en_d      = 1'b0;
        rd_addr_d    = '0;
        wr_en_d      = 1'b0;
        wr_addr_d    = '0;
        wr_data_d    = 32'h0;

        case (state_q)
            IDLE: begin
                // The accept cycle only captures; the captured request is decoded one cycle later.
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!we_q || size_q != 2'b10) begin
                        state_d   = READ;
                        rd_en_d   = 1'b1;
                        rd_addr_d = word_addr;
                    end else begin
                        state_d   = WRITE;
                        wr_en_d   = 1'b1;
                        wr_addr_d = word_addr;
                        wr_data_d = wdata_q;
                    end
                end else if (req_valid_i && ready_q) begin
                    pend_d  = 1'b1;
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    we_d    = req_we_i;
                    wdata_d = req_wdata_i;
                end
            end
            READ: begin
                if (mem_read_valid_i) begin
                    if (we_q) begin
                        state_d   = WRITE;
                        wr_en_d   = 1'b1;
                        wr_addr_d = word_addr;
                        wr_data_d = merged;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_val;
                    end
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = word_addr;
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE) && !pend_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            pend_q       <= 1'b0;
            addr_q       <= 32'h0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= 32'h0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign req_ready_o      = ready_q;
    assign resp_valid_o     = resp_valid_q;
    assign resp_rdata_o     = resp_rdata_q;
    assign resp_err_o       = resp_err_q;
    assign mem_read_en_o    = rd_en_q;
    assign mem_read_addr_o  = rd_addr_q;
    assign mem_write_en_o   = wr_en_q;
    assign mem_write_addr_o = wr_addr_q;
    assign mem_write_data_o = wr_data_q;
endmodule
